// File: rtl/vsm_pkg.sv
// Shared definitions for the VSM operand/result sequencer.
// Contents:
//   VSM_WIDTH    default datapath width of the arithmetic unit
//   vsm_state_e  controller state encoding
//   OP_ADD/SUB   values of Op / AddSub
package vsm_pkg;

   localparam int VSM_WIDTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH_A = 3'd1,
      ST_FETCH_B = 3'd2,
      ST_EXEC    = 3'd3,
      ST_DONE    = 3'd4,
      ST_ABORT   = 3'd5
   } vsm_state_e;

   localparam logic OP_ADD = 1'b0;   // B + A
   localparam logic OP_SUB = 1'b1;   // B - A

endpackage

// File: rtl/vsm_flag_unit.sv
// Combinational carry / zero / signed-overflow evaluation of an arithmetic-unit
// result. The controller registers these values at capture time.
// Ports:
//   a, b     in  WIDTH  operands as driven to the arithmetic unit
//   result   in  WIDTH  value returned by the arithmetic unit
//   carry    in  1      carry out of the arithmetic unit (1 = no borrow on sub)
//   add_sub  in  1      OP_ADD or OP_SUB
//   flag_c   out 1      carry flag
//   flag_z   out 1      result is zero
//   flag_v   out 1      two's-complement overflow
module vsm_flag_unit
   import vsm_pkg::*;
#(
   parameter int WIDTH = VSM_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] result,
   input  logic             carry,
   input  logic             add_sub,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_v
);

   logic same_sign;
   logic res_sign_flip;

   assign same_sign     = (a[WIDTH-1] == b[WIDTH-1]);
   assign res_sign_flip = (result[WIDTH-1] != b[WIDTH-1]);

   assign flag_c = carry;
   assign flag_z = (result == '0);
   // Add overflows only with like-signed operands, subtract only with unlike
   // ones; in both cases the result sign departs from B's sign.
   assign flag_v = ((add_sub == OP_SUB) ? !same_sign : same_sign) && res_sign_flip;

endmodule

// File: rtl/vsm_alu_controller.sv
// Operand and result sequencer for the VSM arithmetic unit. Fetches A then B
// from the internal bus, enables the arithmetic unit for SETTLE_CYCLES cycles,
// captures its result and flags, and signals completion via Busy/Done; a fetch
// that waits IB_TIMEOUT cycles without IbValid aborts with an Error pulse.
// Ports:
//   Clock, nReset          clock, asynchronous active-low reset
//   Start, Op              request and operation (0 add B+A, 1 sub B-A)
//   IB_In, IbValid         internal-bus operand and its valid strobe
//   IB_Alu, Carry          result and carry from the arithmetic unit
//   A, B, AddSub           operand registers and latched operation
//   EnableAlu, BusReq      arithmetic-unit enable, operand request
//   Acc, FlagC/Z/V         captured result and flags
//   Busy, Done, Error      status: not idle, completion pulse, timeout pulse
module vsm_alu_controller
   import vsm_pkg::*;
#(
   parameter int WIDTH         = VSM_WIDTH,
   parameter int SETTLE_CYCLES = 1,
   parameter int IB_TIMEOUT    = 15
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             Start,
   input  logic             Op,
   input  logic [WIDTH-1:0] IB_In,
   input  logic             IbValid,
   input  logic [WIDTH-1:0] IB_Alu,
   input  logic             Carry,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             AddSub,
   output logic             EnableAlu,
   output logic             BusReq,
   output logic [WIDTH-1:0] Acc,
   output logic             FlagC,
   output logic             FlagZ,
   output logic             FlagV,
   output logic             Busy,
   output logic             Done,
   output logic             Error
);

   localparam int                WAIT_W      = $clog2(IB_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(IB_TIMEOUT - 1);
   localparam logic [2:0]        SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

   vsm_state_e        state;
   vsm_state_e        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [2:0]        settle_cnt;
   logic              in_fetch;
   logic              capture;
   logic              flag_c;
   logic              flag_z;
   logic              flag_v;

   vsm_flag_unit #(.WIDTH(WIDTH)) u_flag (
      .a       (A),
      .b       (B),
      .result  (IB_Alu),
      .carry   (Carry),
      .add_sub (AddSub),
      .flag_c  (flag_c),
      .flag_z  (flag_z),
      .flag_v  (flag_v)
   );

   assign in_fetch = (state == ST_FETCH_A) || (state == ST_FETCH_B);
   assign capture  = (state == ST_EXEC) && (state_nxt == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (Start)
               state_nxt = ST_FETCH_A;
            else
               state_nxt = ST_IDLE;
         end
         ST_FETCH_A: begin
            if (IbValid)
               state_nxt = ST_FETCH_B;
            else if (wait_cnt == WAIT_LAST)
               state_nxt = ST_ABORT;
         end
         ST_FETCH_B: begin
            if (IbValid)
               state_nxt = ST_EXEC;
            else if (wait_cnt == WAIT_LAST)
               state_nxt = ST_ABORT;
         end
         ST_EXEC: begin
            if (settle_cnt == SETTLE_LAST)
               state_nxt = ST_DONE;
         end
         ST_ABORT: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         settle_cnt <= '0;
         A          <= '0;
         B          <= '0;
         AddSub     <= 1'b0;
         EnableAlu  <= 1'b0;
         Acc        <= '0;
         FlagC      <= 1'b0;
         FlagZ      <= 1'b0;
         FlagV      <= 1'b0;
      end else begin
         state <= state_nxt;

         // Both counters restart on every state change, so each fetch gets a
         // full timeout window and each EXEC a full settle window.
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (in_fetch)
            wait_cnt <= wait_cnt + 1'b1;

         if (state_nxt != state)
            settle_cnt <= '0;
         else if (state == ST_EXEC)
            settle_cnt <= settle_cnt + 1'b1;

         if ((state == ST_IDLE || state == ST_DONE) && Start)
            AddSub <= Op;
         if (state == ST_FETCH_A && IbValid)
            A <= IB_In;
         if (state == ST_FETCH_B && IbValid)
            B <= IB_In;

         // Registered enable: high exactly for the cycles spent in EXEC.
         EnableAlu <= (state_nxt == ST_EXEC);

         if (capture) begin
            Acc   <= IB_Alu;
            FlagC <= flag_c;
            FlagZ <= flag_z;
            FlagV <= flag_v;
         end
      end
   end

   assign BusReq = in_fetch;
   assign Busy   = (state != ST_IDLE);
   assign Done   = (state == ST_DONE);
   assign Error  = (state == ST_ABORT);

endmodule
